// File: rtl/core_pkg.sv
// Shared definitions for the pipeline control slice: register-file size,
// flush counter width and the control FSM encoding.
package core_pkg;

    localparam int unsigned REG_NUM     = 32;
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned FLUSH_CNT_W = 3;

    // Encoding 2'd3 is unused; the FSM recovers from it to StRun.
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/core_pipe_ctrl_if.sv
// ID-stage issue/hazard handshake between the decode stage (master) and the
// pipeline controller (slave).
interface core_pipe_ctrl_if
    import core_pkg::*;
();

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_rs1_use;
    logic                 id_rs2_use;
    logic [REG_IDX_W-1:0] id_rd;
    logic                 id_rd_wr;
    logic                 id_is_load;
    logic                 ex_allowin;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic                 br_taken;

    logic                 id_issue;
    logic                 id_allowin;
    logic                 stall;
    logic                 flush;
    logic [1:0]           state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_wr,
               id_is_load, ex_allowin, wb_valid, wb_rd, br_taken,
        input  id_issue, id_allowin, stall, flush, state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_wr,
               id_is_load, ex_allowin, wb_valid, wb_rd, br_taken,
        output id_issue, id_allowin, stall, flush, state
    );

endinterface

// File: rtl/core_scoreboard.sv
// Pending-write scoreboard. A retiring write clears its bit before the hazard
// lookup, so an instruction waiting on that register can issue in the WB cycle.
// When an issue and a retire hit the same register in one cycle, the set wins.
module core_scoreboard
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic                 rs1_use_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic                 rs2_use_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    input  logic                 rd_wr_i,
    input  logic                 set_en_i,
    input  logic                 clr_en_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    output logic                 hazard_o
);

    logic [REG_NUM-1:0] pend_q;
    logic [REG_NUM-1:0] pend_d;
    logic [REG_NUM-1:0] pend_eff;

    // Apply the same-cycle WB clear ahead of the lookup.
    always_comb begin
        pend_eff = pend_q;
        if (clr_en_i) begin
            pend_eff[clr_idx_i] = 1'b0;
        end
    end

    // RAW on either source, or WAW on the destination.
    always_comb begin
        hazard_o = id_valid_i & ((rs1_use_i & pend_eff[rs1_i]) |
                                 (rs2_use_i & pend_eff[rs2_i]) |
                                 (rd_wr_i   & pend_eff[rd_i]));
    end

    // Next state: clear first, then set, so a set overrides a colliding clear.
    always_comb begin
        pend_d = pend_eff;
        if (set_en_i && (rd_i != '0)) begin
            pend_d[rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/core_pipe_ctrl.sv
// In-order pipeline issue controller: scoreboard interlock, EX backpressure
// and redirect flush sequencing.
// Build option: define CORE_PIPE_FWD_EN when EX/MEM forwarding exists; then
// only loads are tracked (load-use interlock). Otherwise every rd write is
// tracked until writeback.
module core_pipe_ctrl
    import core_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    core_pipe_ctrl_if.slave bus
);

    localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0] CntOne    = FLUSH_CNT_W'(1);

    pipe_state_e            state_q;
    logic [FLUSH_CNT_W-1:0] cnt_q;
    logic                   hazard;
    logic                   in_flush;
    logic                   issue;
    logic                   set_en;

`ifdef CORE_PIPE_FWD_EN
    // Forwarding covers ALU results; only load data arrives too late.
    assign set_en = issue & bus.id_is_load;
`else
    logic unused_is_load;
    assign unused_is_load = bus.id_is_load;
    assign set_en = issue & bus.id_rd_wr;
`endif

    core_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid_i (bus.id_valid),
        .rs1_i      (bus.id_rs1),
        .rs1_use_i  (bus.id_rs1_use),
        .rs2_i      (bus.id_rs2),
        .rs2_use_i  (bus.id_rs2_use),
        .rd_i       (bus.id_rd),
        .rd_wr_i    (bus.id_rd_wr),
        .set_en_i   (set_en),
        .clr_en_i   (bus.wb_valid),
        .clr_idx_i  (bus.wb_rd),
        .hazard_o   (hazard)
    );

    // Combinational issue/stall/flush decode from current state and inputs.
    always_comb begin
        in_flush       = (state_q == StFlush);
        issue          = bus.id_valid & ~hazard & bus.ex_allowin & ~bus.br_taken & ~in_flush;
        bus.id_issue   = issue;
        bus.id_allowin = ~bus.id_valid | issue;
        bus.stall      = bus.id_valid & ~issue & ~in_flush & ~bus.br_taken;
        bus.flush      = in_flush | bus.br_taken;
        bus.state      = state_q;
    end

    // Control FSM with flush counter; a redirect preempts every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else if (bus.br_taken) begin
            state_q <= StFlush;
            cnt_q   <= FlushLoad;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.id_valid && !issue) begin
                        state_q <= StStall;
                    end
                end
                StStall: begin
                    if (issue || !bus.id_valid) begin
                        state_q <= StRun;
                    end
                end
                StFlush: begin
                    if (cnt_q == '0) begin
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed bench for core_pipe_ctrl (FLUSH_CYCLES = 2). Inputs change 1 ns
// after the rising edge; outputs are checked mid-cycle.
module tb_core_pipe_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    core_pipe_ctrl_if bus ();

    core_pipe_ctrl #(
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] pend;
    assign pend = dut.u_scoreboard.pend_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic wr, input logic ld);
        bus.id_valid   = v;
        bus.id_rs1     = rs1;
        bus.id_rs1_use = u1;
        bus.id_rs2     = rs2;
        bus.id_rs2_use = u2;
        bus.id_rd      = rd;
        bus.id_rd_wr   = wr;
        bus.id_is_load = ld;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0);
        bus.ex_allowin = 1'b1;
        bus.br_taken   = 1'b0;
        #12;
        tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        tests++; if (bus.flush !== 1'b0) begin fails++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        tests++; if (bus.id_issue !== 1'b0) begin fails++; $display("FAIL reset_issue: got %b want 0", bus.id_issue); end
        tests++; if (bus.id_allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin: got %b want 1", bus.id_allowin); end
        tests++; if (pend !== 32'h0) begin fails++; $display("FAIL reset_pend: got %h want 0", pend); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifndef CORE_PIPE_FWD_EN
    task automatic test_raw();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); // ADD x5,x1,x2
        settle();
        tests++; if (bus.id_issue !== 1'b1) begin fails++; $display("FAIL raw_first_issue: got %b want 1", bus.id_issue); end
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0); // ADD x6,x5,x1
        settle();
        tests++; if (pend !== 32'h20) begin fails++; $display("FAIL raw_pend5: got %h want 00000020", pend); end
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL raw_stall: got %b want 1", bus.stall); end
        tests++; if (bus.id_issue !== 1'b0) begin fails++; $display("FAIL raw_hold: got %b want 0", bus.id_issue); end
        tick();
        settle();
        tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL raw_state_stall: got %0d want 1", bus.state); end
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL raw_stall_hold: got %b want 1", bus.stall); end
        tick();
        set_wb(1'b1, 5'd5);
        settle();
        tests++; if (bus.id_issue !== 1'b1) begin fails++; $display("FAIL raw_issue_on_wb: got %b want 1", bus.id_issue); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL raw_stall_release: got %b want 0", bus.stall); end
        tick();
        set_wb(1'b0, 5'd0);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL raw_state_run: got %0d want 0", bus.state); end
        tests++; if (pend !== 32'h40) begin fails++; $display("FAIL raw_pend6: got %h want 00000040", pend); end
        set_wb(1'b1, 5'd6);
        tick();
        set_wb(1'b0, 5'd0);
        settle();
        tests++; if (pend !== 32'h0) begin fails++; $display("FAIL raw_pend_clear: got %h want 0", pend); end
        tick();
    endtask
`else
    task automatic test_load_use();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); // LW x7
        settle();
        tests++; if (bus.id_issue !== 1'b1) begin fails++; $display("FAIL lu_load_issue: got %b want 1", bus.id_issue); end
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0); // ADD x8,x7,x7
        settle();
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
        tick();
        set_wb(1'b1, 5'd7);
        settle();
        tests++; if (bus.id_issue !== 1'b1) begin fails++; $display("FAIL lu_issue_on_wb: got %b want 1", bus.id_issue); end
        tick();
        set_wb(1'b0, 5'd0);
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0); // ADD x9
        settle();
        tests++; if (bus.id_issue !== 1'b1) begin fails++; $display("FAIL lu_alu_issue: got %b want 1", bus.id_issue); end
        tick();
        set_id(1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0); // ADD x10,x9
        settle();
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL lu_fwd_nostall: got %b want 0", bus.stall); end
        tests++; if (pend !== 32'h0) begin fails++; $display("FAIL lu_pend: got %h want 0", pend); end
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask
`endif

    task automatic test_flush();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); // writes x0 only
        bus.br_taken = 1'b1;
        settle();
        tests++; if (bus.flush !== 1'b1) begin fails++; $display("FAIL fl_c0_flush: got %b want 1", bus.flush); end
        tests++; if (bus.id_issue !== 1'b0) begin fails++; $display("FAIL fl_c0_issue: got %b want 0", bus.id_issue); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL fl_c0_stall: got %b want 0", bus.stall); end
        tick();
        bus.br_taken = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            settle();
            tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL fl_c%0d_state: got %0d want 2", c, bus.state); end
            tests++; if (bus.flush !== 1'b1) begin fails++; $display("FAIL fl_c%0d_flush: got %b want 1", c, bus.flush); end
            tests++; if (bus.id_issue !== 1'b0) begin fails++; $display("FAIL fl_c%0d_issue: got %b want 0", c, bus.id_issue); end
            tick();
        end
        settle();
        tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL fl_c3_state: got %0d want 0", bus.state); end
        tests++; if (bus.flush !== 1'b0) begin fails++; $display("FAIL fl_c3_flush: got %b want 0", bus.flush); end
        tests++; if (bus.id_issue !== 1'b1) begin fails++; $display("FAIL fl_c3_issue: got %b want 1", bus.id_issue); end
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        tests++; if (pend !== 32'h0) begin fails++; $display("FAIL fl_x0_pend: got %h want 0", pend); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_flush;
        exp_flush = 6'b011111; // bit c = expected flush in cycle c
        for (int c = 0; c < 6; c++) begin
            bus.br_taken = (c == 0) || (c == 2);
            settle();
            tests++;
            if (bus.flush !== exp_flush[c]) begin
                fails++;
                $display("FAIL b2b_c%0d_flush: got %b want %b", c, bus.flush, exp_flush[c]);
            end
            tick();
        end
        bus.br_taken = 1'b0;
        settle();
        tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL b2b_state_end: got %0d want 0", bus.state); end
        tick();
    endtask

    task automatic test_x0_collision();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); // load into x0
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        settle();
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL x0_nostall: got %b want 0", bus.stall); end
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); // LW x3
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1); // new x3 writer
        set_wb(1'b1, 5'd3);
        settle();
        tests++; if (bus.id_issue !== 1'b1) begin fails++; $display("FAIL coll_issue: got %b want 1", bus.id_issue); end
        tick();
        set_wb(1'b0, 5'd0);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        tests++; if (pend !== 32'h8) begin fails++; $display("FAIL coll_pend3: got %h want 00000008", pend); end
        set_wb(1'b1, 5'd3);
        tick();
        set_wb(1'b0, 5'd0);
    endtask

    task automatic test_backpressure_reset();
        for (int r = 1; r <= 7; r++) begin
            set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 1'b1);
            tick();
        end
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        bus.ex_allowin = 1'b0;
        settle();
        tests++; if (pend !== 32'hFE) begin fails++; $display("FAIL bp_pend: got %h want 000000fe", pend); end
        tests++; if (bus.id_allowin !== 1'b0) begin fails++; $display("FAIL bp_allowin: got %b want 0", bus.id_allowin); end
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL bp_stall: got %b want 1", bus.stall); end
        tick();
        settle();
        tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL bp_state: got %0d want 1", bus.state); end
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++; if (pend !== 32'h0) begin fails++; $display("FAIL rst_pend: got %h want 0", pend); end
        tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", bus.state); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        tests++; if (bus.flush !== 1'b0) begin fails++; $display("FAIL rst_flush: got %b want 0", bus.flush); end
        tick();
        rst_n = 1'b1;
        bus.ex_allowin = 1'b1;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
`ifndef CORE_PIPE_FWD_EN
        test_raw();
`else
        test_load_use();
`endif
        test_flush();
        test_back_to_back();
        test_x0_collision();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
